ctrl_pipe_unit: RTL

CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

---
 rtl/ctrl_pipe_unit.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe_unit.sv
// Pipeline control unit: decodes the ID opcode and carries the controls through the
// ID/EX, EX/MEM and MEM/WB registers. Also detects load-use hazards and counts bubbles.
module ctrl_pipe_unit #(
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         id_opcode,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               flush,
  output logic               id_jump,
  output logic               id_branch,
  output logic               stall,
  output logic               illegal,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic [RADDR_W-1:0] ex_wreg,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_memto_reg,
  output logic               wb_jal,
  output logic [RADDR_W-1:0] wb_wreg,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [ALUOP_W-1:0] ALU_RTYPE  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD    = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND    = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR     = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR    = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_LUI    = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLT    = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLTU   = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_BRANCH = ALUOP_W'(8);

  localparam logic [RADDR_W-1:0] REG_ZERO = '0;
  localparam logic [RADDR_W-1:0] REG_LINK = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  // ID decode
  logic               dec_reg_write;
  logic               dec_reg_dst;
  logic               dec_alu_src;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic               dec_mem_read;
  logic               dec_mem_write;
  logic               dec_memto_reg;
  logic               dec_branch;
  logic               dec_jump;
  logic               dec_jal;
  logic               dec_illegal;
  logic               dec_is_load;
  logic               dec_is_imm;
  logic [RADDR_W-1:0] dec_wreg;
  logic               dec_wr_en;

  // ID/EX
  logic [ALUOP_W-1:0] idex_alu_op_q,   idex_alu_op_d;
  logic               idex_alu_src_q,  idex_alu_src_d;
  logic               idex_reg_dst_q,  idex_reg_dst_d;
  logic               idex_mem_read_q, idex_mem_read_d;
  logic               idex_mem_wr_q,   idex_mem_wr_d;
  logic               idex_reg_wr_q,   idex_reg_wr_d;
  logic               idex_m2r_q,      idex_m2r_d;
  logic               idex_jal_q,      idex_jal_d;
  logic [RADDR_W-1:0] idex_wreg_q,     idex_wreg_d;

  // EX/MEM
  logic               exmem_mem_read_q, exmem_mem_read_d;
  logic               exmem_mem_wr_q,   exmem_mem_wr_d;
  logic               exmem_reg_wr_q,   exmem_reg_wr_d;
  logic               exmem_m2r_q,      exmem_m2r_d;
  logic               exmem_jal_q,      exmem_jal_d;
  logic [RADDR_W-1:0] exmem_wreg_q,     exmem_wreg_d;

  // MEM/WB
  logic               memwb_reg_wr_q, memwb_reg_wr_d;
  logic               memwb_m2r_q,    memwb_m2r_d;
  logic               memwb_jal_q,    memwb_jal_d;
  logic [RADDR_W-1:0] memwb_wreg_q,   memwb_wreg_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble;

  always_comb begin
    dec_reg_write = 1'b0;
    dec_reg_dst   = 1'b0;
    dec_alu_src   = 1'b0;
    dec_alu_op    = ALU_RTYPE;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_memto_reg = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_jal       = 1'b0;
    dec_illegal   = 1'b0;
    dec_is_load   = 1'b0;
    dec_is_imm    = 1'b0;
    case (id_opcode)
      OP_RTYPE: begin
        dec_reg_write = 1'b1;
        dec_reg_dst   = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        dec_is_load   = 1'b1;
        dec_mem_read  = 1'b1;
        dec_memto_reg = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_op    = ALU_ADD;
      end
      OP_SB, OP_SH, OP_SW: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_op    = ALU_ADD;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU: begin
        dec_is_imm    = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        case (id_opcode)
          OP_ANDI:  dec_alu_op = ALU_AND;
          OP_ORI:   dec_alu_op = ALU_OR;
          OP_XORI:  dec_alu_op = ALU_XOR;
          OP_LUI:   dec_alu_op = ALU_LUI;
          OP_SLTI:  dec_alu_op = ALU_SLT;
          OP_SLTIU: dec_alu_op = ALU_SLTU;
          default:  dec_alu_op = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        dec_branch = 1'b1;
        dec_alu_op = ALU_BRANCH;
      end
      OP_J: begin
        dec_jump = 1'b1;
      end
      OP_JAL: begin
        dec_jump      = 1'b1;
        dec_jal       = 1'b1;
        dec_reg_write = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // An undecodable opcode carries no destination so the bubble is all-zero downstream.
  always_comb begin
    if (dec_illegal)      dec_wreg = REG_ZERO;
    else if (dec_reg_dst) dec_wreg = id_rd;
    else if (dec_jal)     dec_wreg = REG_LINK;
    else                  dec_wreg = id_rt;
    dec_wr_en = dec_reg_write && (dec_wreg != REG_ZERO);
  end

  // rt is a source only for opcodes that do not write it as their destination.
  always_comb begin
    stall = idex_mem_read_q && (idex_wreg_q != REG_ZERO) &&
            ((idex_wreg_q == id_rs) ||
             (!dec_is_load && !dec_is_imm && (idex_wreg_q == id_rt)));
    bubble = stall || flush;
  end

  assign id_jump   = dec_jump && !flush;
  assign id_branch = dec_branch && !flush;
  assign illegal   = dec_illegal;

  always_comb begin
    idex_alu_op_d   = '0;
    idex_alu_src_d  = 1'b0;
    idex_reg_dst_d  = 1'b0;
    idex_mem_read_d = 1'b0;
    idex_mem_wr_d   = 1'b0;
    idex_reg_wr_d   = 1'b0;
    idex_m2r_d      = 1'b0;
    idex_jal_d      = 1'b0;
    idex_wreg_d     = '0;
    if (!bubble) begin
      idex_alu_op_d   = dec_alu_op;
      idex_alu_src_d  = dec_alu_src;
      idex_reg_dst_d  = dec_reg_dst;
      idex_mem_read_d = dec_mem_read;
      idex_mem_wr_d   = dec_mem_write;
      idex_reg_wr_d   = dec_wr_en;
      idex_m2r_d      = dec_memto_reg;
      idex_jal_d      = dec_jal;
      idex_wreg_d     = dec_wreg;
    end
  end

  always_comb begin
    exmem_mem_read_d = idex_mem_read_q;
    exmem_mem_wr_d   = idex_mem_wr_q;
    exmem_reg_wr_d   = idex_reg_wr_q;
    exmem_m2r_d      = idex_m2r_q;
    exmem_jal_d      = idex_jal_q;
    exmem_wreg_d     = idex_wreg_q;
    memwb_reg_wr_d   = exmem_reg_wr_q;
    memwb_m2r_d      = exmem_m2r_q;
    memwb_jal_d      = exmem_jal_q;
    memwb_wreg_d     = exmem_wreg_q;
  end

  // A flush coinciding with a stall still inserts only one bubble.
  always_comb begin
    cnt_d = cnt_q;
    if (bubble && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_alu_op_q    <= '0;
      idex_alu_src_q   <= 1'b0;
      idex_reg_dst_q   <= 1'b0;
      idex_mem_read_q  <= 1'b0;
      idex_mem_wr_q    <= 1'b0;
      idex_reg_wr_q    <= 1'b0;
      idex_m2r_q       <= 1'b0;
      idex_jal_q       <= 1'b0;
      idex_wreg_q      <= '0;
      exmem_mem_read_q <= 1'b0;
      exmem_mem_wr_q   <= 1'b0;
      exmem_reg_wr_q   <= 1'b0;
      exmem_m2r_q      <= 1'b0;
      exmem_jal_q      <= 1'b0;
      exmem_wreg_q     <= '0;
      memwb_reg_wr_q   <= 1'b0;
      memwb_m2r_q      <= 1'b0;
      memwb_jal_q      <= 1'b0;
      memwb_wreg_q     <= '0;
      cnt_q            <= '0;
    end else begin
      idex_alu_op_q    <= idex_alu_op_d;
      idex_alu_src_q   <= idex_alu_src_d;
      idex_reg_dst_q   <= idex_reg_dst_d;
      idex_mem_read_q  <= idex_mem_read_d;
      idex_mem_wr_q    <= idex_mem_wr_d;
      idex_reg_wr_q    <= idex_reg_wr_d;
      idex_m2r_q       <= idex_m2r_d;
      idex_jal_q       <= idex_jal_d;
      idex_wreg_q      <= idex_wreg_d;
      exmem_mem_read_q <= exmem_mem_read_d;
      exmem_mem_wr_q   <= exmem_mem_wr_d;
      exmem_reg_wr_q   <= exmem_reg_wr_d;
      exmem_m2r_q      <= exmem_m2r_d;
      exmem_jal_q      <= exmem_jal_d;
      exmem_wreg_q     <= exmem_wreg_d;
      memwb_reg_wr_q   <= memwb_reg_wr_d;
      memwb_m2r_q      <= memwb_m2r_d;
      memwb_jal_q      <= memwb_jal_d;
      memwb_wreg_q     <= memwb_wreg_d;
      cnt_q            <= cnt_d;
    end
  end

  assign ex_alu_op    = idex_alu_op_q;
  assign ex_alu_src   = idex_alu_src_q;
  assign ex_reg_dst   = idex_reg_dst_q;
  assign ex_wreg      = idex_wreg_q;
  assign mem_read     = exmem_mem_read_q;
  assign mem_write    = exmem_mem_wr_q;
  assign wb_reg_write = memwb_reg_wr_q;
  assign wb_memto_reg = memwb_m2r_q;
  assign wb_jal       = memwb_jal_q;
  assign wb_wreg      = memwb_wreg_q;
  assign stall_cnt    = cnt_q;

endmodule
